uart_cmd_arbiter: RTL and testbench
===================================

# uart_cmd_arbiter

- Shares the single command port of the APB UART between two requesters (r0 = host/APB, r1 = test/DMA channel).
- Arbitrates round-robin and drives the UART strobes, address and write data.
- Holds each strobe until the UART reports ready, returns read data and error to the granted requester, and enforces a timeout.
- Sits between the requester fabric and the UART core; it is the only driver of the UART command inputs.

## Interface
- DATA_WIDTH, 32, data bus width (matches UART read/write data)
- ADDR_WIDTH, 8, UART config address width
- TIMEOUT_CYCLES, 1048576, max cycles a strobe is held before abort (≥2)
- PCLK  in  1  clock
- PRESET  in  1  asynchronous, active-high reset
- rN_req_valid  in  1  request from requester N (N = 0, 1; all rN_ ports duplicated)
- rN_req_op  in  2  00 cfg write, 01 cfg read, 10 TX send, 11 RX read
- rN_req_addr  in  ADDR_WIDTH  config address (ignored for TX/RX)
- rN_req_wdata  in  DATA_WIDTH  write/TX data
- rN_req_ready  out  1  one-cycle accept pulse
- rN_rsp_valid  out  1  one-cycle response pulse
- rN_rsp_rdata  out  DATA_WIDTH  read result (0 for writes/TX/timeout)
- rN_rsp_error  out  1  UART error or timeout
- rN_rsp_timeout  out  1  abort due to TIMEOUT_CYCLES
- uart_config_write_detect, uart_config_read_detect, uart_tx_detect, uart_rx_detect  out  1 each  UART strobes; at most one high
- uart_config_address  out  ADDR_WIDTH  to UART
- uart_write_data_in  out  DATA_WIDTH  to UART
- uart_ready  in  1  UART ready
- uart_read_data  in  DATA_WIDTH  UART read data (may be Z when idle)
- uart_error  in  1  UART error flag
- busy  out  1  state ≠ IDLE
- grant_id  out  1  requester owning the current/last transaction

## Operation
- FSM states: IDLE, ISSUE, RESP, DRAIN.
- IDLE:
  - If any req_valid, grant by round-robin: the requester not granted last wins a tie. Reset pointer favours r0.
  - Latch op, addr, wdata and id into command registers; go to ISSUE.
  - Pulse rN_req_ready for the granted requester in the first ISSUE cycle.
- ISSUE:
  - Exactly the strobe decoded from the latched op is high.
  - uart_config_address and uart_write_data_in come from the latched registers and are held stable.
  - A timeout counter (width clog2(TIMEOUT_CYCLES)+1) clears on entry and increments each cycle.
  - uart_ready = 1: capture uart_read_data (read ops only, else 0) and uart_error; go to RESP.
  - Else counter = TIMEOUT_CYCLES-1: capture rdata = 0, error = 1, timeout = 1; go to RESP.
  - uart_ready takes priority over the timeout in the same cycle.
- RESP:
  - All strobes low.
  - Pulse rsp_valid with captured rdata/error/timeout on the granted requester only.
  - Go to DRAIN.
- DRAIN:
  - All strobes low; wait for uart_ready = 0, then go to IDLE.
  - Guarantees the UART's registered done flag has cleared before the next issue.
- Update the last-grant pointer at grant time.
- The non-granted requester's outputs stay 0 throughout.
- Requesters hold req_valid and payload until req_ready, then drop req_valid. A still-high req_valid after RESP is a new request.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE; all strobes 0; uart_config_address and uart_write_data_in 0.
  - All req_ready, rsp_* outputs 0; busy 0; grant_id 0; pointer favours r0.
- Reset during ISSUE drops the strobe in the same instant; no response is issued.
- Request seen in IDLE in cycle n: strobe and req_ready high in cycle n+1.
- uart_ready first high in cycle m: strobe high through cycle m, low from m+1; rsp_valid in cycle m+1.
- Minimum turnaround: UART ready 1 cycle after strobe (opt_done) gives ready in n+2, rsp_valid in n+3.
  - The UART keeps ready high through n+3, so DRAIN sees ready = 0 in n+4; back in IDLE at n+5.
  - Next strobe at n+6 earliest.
- Timeout: strobe high for exactly TIMEOUT_CYCLES cycles, then rsp_valid the following cycle.
- Inputs on the requester port are not sampled outside IDLE.

## Test plan
- r0 cfg write: addr baud_config, wdata 115200 → uart_config_write_detect held until ready. Then r0 cfg read returns rsp_rdata = 115200, rsp_error = 0.
- r0 and r1 both valid in IDLE after reset → r0 granted first, r1 next, r0 again. grant_id alternates 0,1,0 over three back-to-back requests each.
- r1 TX send 0xA5 at 9600 baud → uart_tx_detect high until TX_done-driven ready. One rsp_valid on r1 only, rdata = 0; no strobe while ready is still high.
- r0 RX read with UART ready stuck 0, TIMEOUT_CYCLES = 16 → strobe high exactly 16 cycles. rsp_valid with error = 1, timeout = 1, rdata = 0.
- Assert PRESET mid-ISSUE → all strobes and outputs 0 immediately, no rsp_valid. After release a new r1 request completes normally and r0 is favoured on the next tie.

Source files
------------

// File: rtl/uart_cmd_arbiter.sv
// Round-robin arbiter sharing the UART command port between two requesters.
// Holds each strobe until uart_ready or timeout, then returns one response pulse.
module uart_cmd_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  r0_req_valid,
    input  logic [1:0]            r0_req_op,
    input  logic [ADDR_WIDTH-1:0] r0_req_addr,
    input  logic [DATA_WIDTH-1:0] r0_req_wdata,
    output logic                  r0_req_ready,
    output logic                  r0_rsp_valid,
    output logic [DATA_WIDTH-1:0] r0_rsp_rdata,
    output logic                  r0_rsp_error,
    output logic                  r0_rsp_timeout,
    input  logic                  r1_req_valid,
    input  logic [1:0]            r1_req_op,
    input  logic [ADDR_WIDTH-1:0] r1_req_addr,
    input  logic [DATA_WIDTH-1:0] r1_req_wdata,
    output logic                  r1_req_ready,
    output logic                  r1_rsp_valid,
    output logic [DATA_WIDTH-1:0] r1_rsp_rdata,
    output logic                  r1_rsp_error,
    output logic                  r1_rsp_timeout,
    output logic                  uart_config_write_detect,
    output logic                  uart_config_read_detect,
    output logic                  uart_tx_detect,
    output logic                  uart_rx_detect,
    output logic [ADDR_WIDTH-1:0] uart_config_address,
    output logic [DATA_WIDTH-1:0] uart_write_data_in,
    input  logic                  uart_ready,
    input  logic [DATA_WIDTH-1:0] uart_read_data,
    input  logic                  uart_error,
    output logic                  busy,
    output logic                  grant_id
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  id_q, id_d;
    logic                  ptr_q, ptr_d;
    logic                  first_q, first_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  to_q, to_d;
    logic                  gnt;

    // ptr_q remembers the last granted requester; reset value 1 lets r0 win the first tie.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b1;
            first_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        first_d = 1'b0;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        to_d    = to_q;
        gnt     = (r0_req_valid && r1_req_valid) ? ~ptr_q : r1_req_valid;
        case (state_q)
            IDLE: begin
                if (r0_req_valid || r1_req_valid) begin
                    id_d    = gnt;
                    ptr_d   = gnt;
                    op_d    = gnt ? r1_req_op    : r0_req_op;
                    addr_d  = gnt ? r1_req_addr  : r0_req_addr;
                    wdata_d = gnt ? r1_req_wdata : r0_req_wdata;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A ready in the final counted cycle still completes normally.
                if (uart_ready) begin
                    rdata_d = op_q[0] ? uart_read_data : '0;
                    err_d   = uart_error;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = DRAIN;
            DRAIN:   if (!uart_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        uart_config_write_detect = 1'b0;
        uart_config_read_detect  = 1'b0;
        uart_tx_detect           = 1'b0;
        uart_rx_detect           = 1'b0;
        uart_config_address      = addr_q;
        uart_write_data_in       = wdata_q;
        r0_req_ready             = 1'b0;
        r1_req_ready             = 1'b0;
        r0_rsp_valid             = 1'b0;
        r0_rsp_rdata             = '0;
        r0_rsp_error             = 1'b0;
        r0_rsp_timeout           = 1'b0;
        r1_rsp_valid             = 1'b0;
        r1_rsp_rdata             = '0;
        r1_rsp_error             = 1'b0;
        r1_rsp_timeout           = 1'b0;
        busy                     = (state_q != IDLE);
        grant_id                 = id_q;
        if (state_q == ISSUE) begin
            case (op_q)
                2'b00:   uart_config_write_detect = 1'b1;
                2'b01:   uart_config_read_detect  = 1'b1;
                2'b10:   uart_tx_detect           = 1'b1;
                default: uart_rx_detect           = 1'b1;
            endcase
            r0_req_ready = first_q && !id_q;
            r1_req_ready = first_q && id_q;
        end
        if (state_q == RESP) begin
            if (id_q) begin
                r1_rsp_valid   = 1'b1;
                r1_rsp_rdata   = rdata_q;
                r1_rsp_error   = err_q;
                r1_rsp_timeout = to_q;
            end else begin
                r0_rsp_valid   = 1'b1;
                r0_rsp_rdata   = rdata_q;
                r0_rsp_error   = err_q;
                r0_rsp_timeout = to_q;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Directed bench for uart_cmd_arbiter: vector table of transactions plus a
// hand-written asynchronous-reset-during-ISSUE sequence, with a small UART model.
module tb_uart_cmd_arbiter;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          r0_req_valid = 1'b0, r1_req_valid = 1'b0;
    logic [1:0]    r0_req_op = '0, r1_req_op = '0;
    logic [AW-1:0] r0_req_addr = '0, r1_req_addr = '0;
    logic [DW-1:0] r0_req_wdata = '0, r1_req_wdata = '0;
    logic          r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid;
    logic [DW-1:0] r0_rsp_rdata, r1_rsp_rdata;
    logic          r0_rsp_error, r1_rsp_error, r0_rsp_timeout, r1_rsp_timeout;
    logic          uart_config_write_detect, uart_config_read_detect, uart_tx_detect, uart_rx_detect;
    logic [AW-1:0] uart_config_address;
    logic [DW-1:0] uart_write_data_in;
    logic          uart_ready = 1'b0;
    logic [DW-1:0] uart_read_data = 32'hDEAD_BEEF;
    logic          uart_error = 1'b0;
    logic          busy, grant_id;
    logic [3:0]    strb;

    int            total = 0;
    int            bad = 0;
    int            uart_dly = 0;
    logic [31:0]   uart_rd_v = '0;
    logic          uart_err_v = 1'b0;

    assign strb = {uart_rx_detect, uart_tx_detect, uart_config_read_detect, uart_config_write_detect};

    uart_cmd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .r0_req_valid(r0_req_valid), .r0_req_op(r0_req_op), .r0_req_addr(r0_req_addr),
        .r0_req_wdata(r0_req_wdata), .r0_req_ready(r0_req_ready), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_rdata(r0_rsp_rdata), .r0_rsp_error(r0_rsp_error), .r0_rsp_timeout(r0_rsp_timeout),
        .r1_req_valid(r1_req_valid), .r1_req_op(r1_req_op), .r1_req_addr(r1_req_addr),
        .r1_req_wdata(r1_req_wdata), .r1_req_ready(r1_req_ready), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_rdata(r1_rsp_rdata), .r1_rsp_error(r1_rsp_error), .r1_rsp_timeout(r1_rsp_timeout),
        .uart_config_write_detect(uart_config_write_detect), .uart_config_read_detect(uart_config_read_detect),
        .uart_tx_detect(uart_tx_detect), .uart_rx_detect(uart_rx_detect),
        .uart_config_address(uart_config_address), .uart_write_data_in(uart_write_data_in),
        .uart_ready(uart_ready), .uart_read_data(uart_read_data), .uart_error(uart_error),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic        v0, v1;
        logic [1:0]  op0, op1;
        logic [7:0]  a0, a1;
        logic [31:0] w0, w1;
        logic [31:0] dly;    // ready this many cycles after strobe rises; 0 = never
        logic [31:0] urd;
        logic        uerr;
        logic        egid;
        logic [31:0] erd;
        logic        eerr, eto;
        logic [31:0] ecyc;   // expected number of strobe-high cycles
    } vec_t;

    vec_t vecs[12];
    vec_t post[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART model: raises ready after the programmed delay, keeps it one cycle past the strobe.
    initial begin : uart_model
        int   seen;
        logic prev, pend;
        seen = 0; prev = 1'b0; pend = 1'b0;
        forever begin
            @(posedge PCLK); #1;
            if (strb != 4'b0) begin
                if (!prev) begin
                    chk("strobe_rise_ready_low", 32'(uart_ready), 32'd0);
                    chk("strobe_onehot", 32'($countones(strb)), 32'd1);
                end
                if (uart_dly > 0 && seen == uart_dly && !uart_ready) begin
                    uart_ready = 1'b1; uart_read_data = uart_rd_v; uart_error = uart_err_v;
                end
                seen++;
            end else begin
                seen = 0;
                if (uart_ready) begin
                    if (pend) begin
                        uart_ready = 1'b0; uart_read_data = 32'hDEAD_BEEF; uart_error = 1'b0; pend = 1'b0;
                    end else begin
                        pend = 1'b1;
                    end
                end
            end
            prev = (strb != 4'b0);
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int          k, cyc;
        logic [1:0]  gop;
        logic [7:0]  ga;
        logic [31:0] gw;
        k = 0;
        while (busy && k < 200) begin @(posedge PCLK); #1; k++; end
        chk("idle_wait_expired", 32'(k >= 200), 32'd0);
        uart_dly = int'(v.dly); uart_rd_v = v.urd; uart_err_v = v.uerr;
        r0_req_op = v.op0; r0_req_addr = v.a0; r0_req_wdata = v.w0;
        r1_req_op = v.op1; r1_req_addr = v.a1; r1_req_wdata = v.w1;
        r0_req_valid = v.v0; r1_req_valid = v.v1;
        gop = v.egid ? v.op1 : v.op0;
        ga  = v.egid ? v.a1 : v.a0;
        gw  = v.egid ? v.w1 : v.w0;
        @(posedge PCLK); #1;
        chk("req_ready", 32'(v.egid ? r1_req_ready : r0_req_ready), 32'd1);
        chk("other_req_ready", 32'(v.egid ? r0_req_ready : r1_req_ready), 32'd0);
        chk("grant_id", 32'(grant_id), 32'(v.egid));
        chk("busy", 32'(busy), 32'd1);
        chk("strobe", 32'(strb), 32'(4'b0001 << gop));
        chk("uart_addr", 32'(uart_config_address), 32'(ga));
        chk("uart_wdata", uart_write_data_in, gw);
        if (v.egid) r1_req_valid = 1'b0; else r0_req_valid = 1'b0;
        cyc = 0; k = 0;
        while (!(r0_rsp_valid || r1_rsp_valid) && k < 200) begin
            if (strb != 4'b0) cyc++;
            @(posedge PCLK); #1;
            chk("req_ready_single_pulse", 32'(r0_req_ready | r1_req_ready), 32'd0);
            k++;
        end
        chk("rsp_wait_expired", 32'(k >= 200), 32'd0);
        chk("rsp_valid", 32'(v.egid ? r1_rsp_valid : r0_rsp_valid), 32'd1);
        chk("other_rsp_valid", 32'(v.egid ? r0_rsp_valid : r1_rsp_valid), 32'd0);
        chk("rsp_rdata", v.egid ? r1_rsp_rdata : r0_rsp_rdata, v.erd);
        chk("other_rsp_rdata", v.egid ? r0_rsp_rdata : r1_rsp_rdata, 32'd0);
        chk("rsp_error", 32'(v.egid ? r1_rsp_error : r0_rsp_error), 32'(v.eerr));
        chk("rsp_timeout", 32'(v.egid ? r1_rsp_timeout : r0_rsp_timeout), 32'(v.eto));
        chk("strobe_low_in_resp", 32'(strb), 32'd0);
        chk("strobe_cycles", 32'(cyc), v.ecyc);
        $display("txn %0d: gid=%0d op=%0d rdata=%0h err=%0d to=%0d strobe_cycles=%0d",
                 idx, v.egid, gop, v.egid ? r1_rsp_rdata : r0_rsp_rdata,
                 v.egid ? r1_rsp_error : r0_rsp_error, v.egid ? r1_rsp_timeout : r0_rsp_timeout, cyc);
        @(posedge PCLK); #1;
        chk("rsp_single_pulse", 32'(r0_rsp_valid | r1_rsp_valid), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin : main
        // Tie between r0 cfg write and r1 TX: grants alternate starting with r0.
        for (int i = 0; i < 6; i++)
            vecs[i] = '{1'b1, 1'b1, 2'b00, 2'b10, 8'h10, 8'h00, 32'h1111_0000, 32'h0000_00A5,
                        32'd1, 32'hDEAD_BEEF, 1'b0, 1'(i % 2), 32'd0, 1'b0, 1'b0, 32'd2};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 2'b00, 8'h04, 8'h00, 32'd115200, 32'd0,
                     32'd1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd2};
        vecs[7]  = '{1'b1, 1'b0, 2'b01, 2'b00, 8'h04, 8'h00, 32'd0, 32'd0,
                     32'd2, 32'd115200, 1'b0, 1'b0, 32'd115200, 1'b0, 1'b0, 32'd3};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 2'b10, 8'h00, 8'h00, 32'd0, 32'h0000_00A5,
                     32'd10, 32'h1234_5678, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 32'd11};
        vecs[9]  = '{1'b1, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 32'd0, 32'd0,
                     32'd0, 32'h0000_0055, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd16};
        vecs[10] = '{1'b0, 1'b1, 2'b00, 2'b01, 8'h00, 8'h04, 32'd0, 32'd0,
                     32'd15, 32'd115200, 1'b1, 1'b1, 32'd115200, 1'b1, 1'b0, 32'd16};
        vecs[11] = '{1'b1, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 32'd0, 32'd0,
                     32'd1, 32'h0000_003C, 1'b0, 1'b0, 32'h0000_003C, 1'b0, 1'b0, 32'd2};
        post[0]  = vecs[0];
        post[1]  = '{1'b0, 1'b1, 2'b00, 2'b10, 8'h00, 8'h00, 32'd0, 32'h0000_00A5,
                     32'd1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 32'd2};
        post[2]  = vecs[0];

        repeat (2) @(posedge PCLK);
        #1;
        chk("reset_strobes", 32'(strb), 32'd0);
        chk("reset_req_ready", 32'({r0_req_ready, r1_req_ready}), 32'd0);
        chk("reset_rsp_valid", 32'({r0_rsp_valid, r1_rsp_valid}), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        chk("reset_addr", 32'(uart_config_address), 32'd0);
        chk("reset_wdata", uart_write_data_in, 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset while r0 holds a never-acknowledged strobe.
        begin : reset_mid_issue
            int k;
            k = 0;
            while (busy && k < 200) begin @(posedge PCLK); #1; k++; end
            uart_dly = 0;
            r0_req_op = 2'b00; r0_req_addr = 8'h20; r0_req_wdata = 32'h0000_CAFE; r0_req_valid = 1'b1;
            @(posedge PCLK); #1;
            chk("pre_reset_strobe", 32'(strb), 32'd1);
            r0_req_valid = 1'b0;
            repeat (2) @(posedge PCLK);
            #3;
            PRESET = 1'b1;
            #1;
            chk("async_reset_strobes", 32'(strb), 32'd0);
            chk("async_reset_busy", 32'(busy), 32'd0);
            chk("async_reset_addr", 32'(uart_config_address), 32'd0);
            chk("async_reset_wdata", uart_write_data_in, 32'd0);
            chk("async_reset_req_ready", 32'({r0_req_ready, r1_req_ready}), 32'd0);
            for (int c = 0; c < 3; c++) begin
                @(posedge PCLK); #1;
                chk("no_rsp_during_reset", 32'({r0_rsp_valid, r1_rsp_valid}), 32'd0);
            end
            PRESET = 1'b0;
            @(posedge PCLK); #1;
            chk("no_rsp_after_reset", 32'({r0_rsp_valid, r1_rsp_valid}), 32'd0);
        end

        for (int i = 0; i < 3; i++) run_vec(post[i], 12 + i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
